// File: rtl/game_pixel_mapper.sv
// game_pixel_mapper
//   Renders the player ball, up to NUM_OBS circular obstacles, side borders and
//   a level-shaded background through a 3-stage registered pixel pipeline, and
//   runs the PLAY / HIT / FINISH play-state machine.
//
//   Ports:
//     Clk, Reset_n          pixel clock, synchronous active-low reset
//     frame_start           one-cycle pulse per frame (vsync)
//     pix_valid             DrawX/DrawY are in the active region
//     DrawX, DrawY          current pixel coordinates
//     BallX, BallY          ball centre
//     Ball_size             radius shared by the ball and all obstacles
//     ObsX, ObsY            packed obstacle centres, channel i at [10i+9:10i]
//     obs_en                per-obstacle enable (draw and collide)
//     level                 palette / level select
//     Red, Green, Blue      registered pixel colour, 3 cycles after DrawX/DrawY
//     rgb_valid             pix_valid delayed 3 cycles
//     collision_vec         registered per-obstacle overlap
//     collision             high while in HIT
//     reset_player          one-cycle pulse on HIT entry
//     finish_line_reached   high while in FINISH
module game_pixel_mapper #(
    parameter int NUM_OBS    = 4,
    parameter int FINISH_X   = 580,
    parameter int BORDER_L   = 50,
    parameter int BORDER_R   = 590,
    parameter int HIT_FRAMES = 30
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   frame_start,
    input  logic                   pix_valid,
    input  logic [9:0]             DrawX,
    input  logic [9:0]             DrawY,
    input  logic [9:0]             BallX,
    input  logic [9:0]             BallY,
    input  logic [9:0]             Ball_size,
    input  logic [10*NUM_OBS-1:0]  ObsX,
    input  logic [10*NUM_OBS-1:0]  ObsY,
    input  logic [NUM_OBS-1:0]     obs_en,
    input  logic [1:0]             level,
    output logic [3:0]             Red,
    output logic [3:0]             Green,
    output logic [3:0]             Blue,
    output logic                   rgb_valid,
    output logic [NUM_OBS-1:0]     collision_vec,
    output logic                   collision,
    output logic                   reset_player,
    output logic                   finish_line_reached
);

    localparam int         CNT_W      = $clog2(HIT_FRAMES + 1);
    localparam logic [9:0] FINISH_X_V = 10'(FINISH_X);
    localparam logic [9:0] BORDER_L_V = 10'(BORDER_L);
    localparam logic [9:0] BORDER_R_V = 10'(BORDER_R);

    typedef enum logic [1:0] {ST_PLAY, ST_HIT, ST_FINISH} state_t;

    function automatic logic signed [10:0] sdiff(input logic [9:0] a, input logic [9:0] b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

    function automatic logic [10:0] sabs(input logic signed [10:0] d);
        logic signed [10:0] n;
        n = -d;
        return d[10] ? $unsigned(n) : $unsigned(d);
    endfunction

    function automatic logic [20:0] sq(input logic signed [10:0] d);
        logic signed [21:0] p;
        p = d * d;
        return p[20:0];
    endfunction

    function automatic logic in_circle(input logic signed [10:0] dx,
                                       input logic signed [10:0] dy,
                                       input logic [9:0]         r);
        logic [21:0] r22;
        r22 = {12'd0, r};
        return ({1'b0, sq(dx)} + {1'b0, sq(dy)}) <= (r22 * r22);
    endfunction

    function automatic logic [3:0] sat_sub(input logic [3:0] a, input logic [3:0] b);
        return (a > b) ? (a - b) : 4'd0;
    endfunction

    function automatic logic [11:0] palette(input logic [1:0] lvl);
        case (lvl)
            2'd0:    return 12'h533;
            2'd1:    return 12'h642;
            2'd2:    return 12'hF36;
            default: return 12'hF00;
        endcase
    endfunction

    // S1 registers
    logic                vld_p1_d,    vld_p1_q;
    logic signed [10:0]  dxb_p1_d,    dxb_p1_q;
    logic signed [10:0]  dyb_p1_d,    dyb_p1_q;
    logic signed [10:0]  dxo_p1_d [NUM_OBS];
    logic signed [10:0]  dxo_p1_q [NUM_OBS];
    logic signed [10:0]  dyo_p1_d [NUM_OBS];
    logic signed [10:0]  dyo_p1_q [NUM_OBS];
    logic [NUM_OBS-1:0]  en_p1_d,     en_p1_q;
    logic [9:0]          rad_p1_d,    rad_p1_q;
    logic [1:0]          lvl_p1_d,    lvl_p1_q;
    logic                border_p1_d, border_p1_q;
    logic [3:0]          shade_p1_d,  shade_p1_q;
    // S2 registers
    logic                vld_p2_d,    vld_p2_q;
    logic                ball_p2_d,   ball_p2_q;
    logic                obs_p2_d,    obs_p2_q;
    logic                border_p2_d, border_p2_q;
    logic [3:0]          shade_p2_d,  shade_p2_q;
    logic [1:0]          lvl_p2_d,    lvl_p2_q;
    // S3 registers
    logic [11:0]         base_p2;
    logic [11:0]         rgb_d,       rgb_q;
    logic                rgb_valid_d, rgb_valid_q;
    // Control
    logic [NUM_OBS-1:0]  cvec_d,      cvec_q;
    state_t              state_d,     state_q;
    logic [CNT_W-1:0]    cnt_d,       cnt_q;
    logic [1:0]          lvl_lat_d,   lvl_lat_q;
    logic                rst_pl_d,    rst_pl_q;

    always_comb begin
        // ---- stage 0 -> S1: signed offsets from ball and obstacle centres
        vld_p1_d    = pix_valid;
        dxb_p1_d    = sdiff(DrawX, BallX);
        dyb_p1_d    = sdiff(DrawY, BallY);
        for (int i = 0; i < NUM_OBS; i++) begin
            dxo_p1_d[i] = sdiff(DrawX, ObsX[10*i +: 10]);
            dyo_p1_d[i] = sdiff(DrawY, ObsY[10*i +: 10]);
        end
        en_p1_d     = obs_en;
        rad_p1_d    = Ball_size;
        lvl_p1_d    = level;
        border_p1_d = (DrawX <= BORDER_L_V) || (DrawX >= BORDER_R_V);
        shade_p1_d  = {1'b0, DrawX[9:7]} + {1'b0, DrawY[9:7]};

        // ---- S1 -> S2: squares and circle membership
        vld_p2_d    = vld_p1_q;
        ball_p2_d   = in_circle(dxb_p1_q, dyb_p1_q, rad_p1_q);
        obs_p2_d    = 1'b0;
        for (int i = 0; i < NUM_OBS; i++) begin
            if (en_p1_q[i] && in_circle(dxo_p1_q[i], dyo_p1_q[i], rad_p1_q)) begin
                obs_p2_d = 1'b1;
            end
        end
        border_p2_d = border_p1_q;
        shade_p2_d  = shade_p1_q;
        lvl_p2_d    = lvl_p1_q;

        // ---- S2 -> S3: priority mux and palette
        base_p2     = palette(lvl_p2_q);
        rgb_valid_d = vld_p2_q;
        if (!vld_p2_q) begin
            rgb_d = 12'h000;
        end else if (ball_p2_q) begin
            rgb_d = (state_q == ST_HIT) ? 12'hF00 : 12'h0F0;
        end else if (obs_p2_q) begin
            rgb_d = ~base_p2;
        end else if (border_p2_q) begin
            rgb_d = 12'h061;
        end else begin
            rgb_d = {sat_sub(base_p2[11:8], shade_p2_q),
                     sat_sub(base_p2[7:4],  shade_p2_q),
                     sat_sub(base_p2[3:0],  shade_p2_q)};
        end
    end

    // Bounding-box overlap between ball and each enabled obstacle.
    always_comb begin
        cvec_d = '0;
        for (int i = 0; i < NUM_OBS; i++) begin
            cvec_d[i] = obs_en[i]
                     && (sabs(sdiff(BallX, ObsX[10*i +: 10])) < {Ball_size, 1'b0})
                     && (sabs(sdiff(BallY, ObsY[10*i +: 10])) < {Ball_size, 1'b0});
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lvl_lat_d = lvl_lat_q;
        rst_pl_d  = 1'b0;
        case (state_q)
            ST_PLAY: begin
                if (|cvec_q) begin
                    state_d  = ST_HIT;
                    cnt_d    = '0;
                    rst_pl_d = 1'b1;
                end else if ((BallX >= FINISH_X_V) && !(|cvec_d)) begin
                    // An overlap seen this cycle becomes a HIT next cycle; it must
                    // not be pre-empted by a finish taken on the same inputs.
                    state_d   = ST_FINISH;
                    lvl_lat_d = level;
                end
            end
            ST_HIT: begin
                if (frame_start) begin
                    if (cnt_q == CNT_W'(HIT_FRAMES - 1)) begin
                        state_d = ST_PLAY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_FINISH: begin
                if (level != lvl_lat_q) begin
                    state_d = ST_PLAY;
                end
            end
            default: state_d = ST_PLAY;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            vld_p1_q    <= 1'b0;
            dxb_p1_q    <= '0;
            dyb_p1_q    <= '0;
            for (int i = 0; i < NUM_OBS; i++) begin
                dxo_p1_q[i] <= '0;
                dyo_p1_q[i] <= '0;
            end
            en_p1_q     <= '0;
            rad_p1_q    <= '0;
            lvl_p1_q    <= '0;
            border_p1_q <= 1'b0;
            shade_p1_q  <= '0;
            vld_p2_q    <= 1'b0;
            ball_p2_q   <= 1'b0;
            obs_p2_q    <= 1'b0;
            border_p2_q <= 1'b0;
            shade_p2_q  <= '0;
            lvl_p2_q    <= '0;
            rgb_q       <= '0;
            rgb_valid_q <= 1'b0;
            cvec_q      <= '0;
            state_q     <= ST_PLAY;
            cnt_q       <= '0;
            lvl_lat_q   <= '0;
            rst_pl_q    <= 1'b0;
        end else begin
            vld_p1_q    <= vld_p1_d;
            dxb_p1_q    <= dxb_p1_d;
            dyb_p1_q    <= dyb_p1_d;
            for (int i = 0; i < NUM_OBS; i++) begin
                dxo_p1_q[i] <= dxo_p1_d[i];
                dyo_p1_q[i] <= dyo_p1_d[i];
            end
            en_p1_q     <= en_p1_d;
            rad_p1_q    <= rad_p1_d;
            lvl_p1_q    <= lvl_p1_d;
            border_p1_q <= border_p1_d;
            shade_p1_q  <= shade_p1_d;
            vld_p2_q    <= vld_p2_d;
            ball_p2_q   <= ball_p2_d;
            obs_p2_q    <= obs_p2_d;
            border_p2_q <= border_p2_d;
            shade_p2_q  <= shade_p2_d;
            lvl_p2_q    <= lvl_p2_d;
            rgb_q       <= rgb_d;
            rgb_valid_q <= rgb_valid_d;
            cvec_q      <= cvec_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lvl_lat_q   <= lvl_lat_d;
            rst_pl_q    <= rst_pl_d;
        end
    end

    assign Red                 = rgb_q[11:8];
    assign Green               = rgb_q[7:4];
    assign Blue                = rgb_q[3:0];
    assign rgb_valid           = rgb_valid_q;
    assign collision_vec       = cvec_q;
    assign collision           = (state_q == ST_HIT);
    assign reset_player        = rst_pl_q;
    assign finish_line_reached = (state_q == ST_FINISH);

endmodule

// File: tb/tb_game_pixel_mapper.sv
// tb_game_pixel_mapper
//   Directed bench for game_pixel_mapper: pixel colours, priority, palette,
//   shading saturation, signed geometry, collision/HIT timing, finish line and
//   mid-HIT reset.
module tb_game_pixel_mapper;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        frame_start;
    logic        pix_valid;
    logic [9:0]  DrawX, DrawY, BallX, BallY, Ball_size;
    logic [39:0] ObsX, ObsY;
    logic [3:0]  obs_en;
    logic [1:0]  level;
    logic [3:0]  Red, Green, Blue;
    logic        rgb_valid;
    logic [3:0]  collision_vec;
    logic        collision, reset_player, finish_line_reached;

    int n_checks = 0;
    int n_fail   = 0;

    game_pixel_mapper dut (
        .Clk                 (Clk),
        .Reset_n             (Reset_n),
        .frame_start         (frame_start),
        .pix_valid           (pix_valid),
        .DrawX               (DrawX),
        .DrawY               (DrawY),
        .BallX               (BallX),
        .BallY               (BallY),
        .Ball_size           (Ball_size),
        .ObsX                (ObsX),
        .ObsY                (ObsY),
        .obs_en              (obs_en),
        .level               (level),
        .Red                 (Red),
        .Green               (Green),
        .Blue                (Blue),
        .rgb_valid           (rgb_valid),
        .collision_vec       (collision_vec),
        .collision           (collision),
        .reset_player        (reset_player),
        .finish_line_reached (finish_line_reached)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic set_obs(input int i, input int x, input int y);
        ObsX[10*i +: 10] = 10'(x);
        ObsY[10*i +: 10] = 10'(y);
    endtask

    task automatic pixel(input string tag, input int x, input int y, input logic [11:0] exp);
        DrawX = 10'(x);
        DrawY = 10'(y);
        pix_valid = 1'b1;
        tick(3);
        check(tag, {Red, Green, Blue}, exp);
    endtask

    initial begin
        Reset_n = 1'b0; frame_start = 1'b0; pix_valid = 1'b0;
        DrawX = '0; DrawY = '0;
        BallX = 10'd100; BallY = 10'd100; Ball_size = 10'd8;
        ObsX = '0; ObsY = '0; obs_en = '0; level = 2'd0;
        for (int i = 0; i < 4; i++) set_obs(i, 300, 300);
        tick(3);

        // Reset state
        check("rst_valid", rgb_valid, 0);
        check("rst_rgb", {Red, Green, Blue}, 0);
        check("rst_cvec", collision_vec, 0);
        check("rst_coll", collision, 0);
        check("rst_rp", reset_player, 0);
        check("rst_fin", finish_line_reached, 0);
        Reset_n = 1'b1;

        // Latency: valid appears exactly on the third edge
        DrawX = 10'd100; DrawY = 10'd100; pix_valid = 1'b1;
        tick(2);
        check("lat_valid_early", rgb_valid, 0);
        tick(1);
        check("lat_valid", rgb_valid, 1);
        check("ball_centre", {Red, Green, Blue}, 12'h0F0);

        pixel("ball_edge", 108, 100, 12'h0F0);
        pixel("ball_out", 109, 100, 12'h533);
        pixel("bg_shade1", 130, 100, 12'h422);
        pixel("border_l", 50, 10, 12'h061);
        pixel("bg_l_inside", 51, 10, 12'h533);
        pixel("border_r", 590, 10, 12'h061);
        pixel("bg_sat", 589, 10, 12'h100);
        level = 2'd3; pixel("lvl3", 300, 300, 12'hB00);
        level = 2'd2; pixel("lvl2", 300, 300, 12'hB02);
        level = 2'd1; pixel("lvl1", 300, 300, 12'h200);
        level = 2'd0;

        // Inactive pixel
        DrawX = 10'd100; DrawY = 10'd100; pix_valid = 1'b0;
        tick(3);
        check("inactive_rgb", {Red, Green, Blue}, 0);
        check("inactive_valid", rgb_valid, 0);

        // Signed distance near the origin
        BallX = 10'd5; BallY = 10'd5;
        pixel("underflow_ball", 0, 0, 12'h0F0);

        // Disabled obstacle is neither drawn nor collided
        BallX = 10'd190; BallY = 10'd150;
        set_obs(2, 200, 150); obs_en = 4'b0000;
        pixel("obs_dis_pix", 200, 150, 12'h311);
        check("obs_dis_cvec", collision_vec, 0);
        check("obs_dis_coll", collision, 0);

        // Enabled obstacle drawn with inverted base
        BallX = 10'd100; BallY = 10'd100;
        set_obs(1, 300, 300); obs_en = 4'b0010;
        pixel("obs_draw", 300, 300, 12'hACC);
        check("obs_draw_cvec", collision_vec, 0);

        // Collision, HIT entry, frame counting
        pix_valid = 1'b0;
        obs_en = 4'b0100; BallX = 10'd190; BallY = 10'd150;
        tick(1);
        check("hit_cvec", collision_vec, 4'b0100);
        check("hit_coll_early", collision, 0);
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        check("hit_coll", collision, 1);
        check("hit_rp", reset_player, 1);
        BallX = 10'd200; BallY = 10'd150;
        DrawX = 10'd200; DrawY = 10'd150; pix_valid = 1'b1;
        tick(1);
        check("hit_rp_once", reset_player, 0);
        tick(2);
        check("hit_ball_prio", {Red, Green, Blue}, 12'hF00);
        BallX = 10'd100; BallY = 10'd100; pix_valid = 1'b0;
        for (int f = 0; f < 29; f++) begin
            frame_start = 1'b1; tick(1); frame_start = 1'b0; tick(2);
        end
        check("hit_hold29", collision, 1);
        frame_start = 1'b1; tick(1); frame_start = 1'b0;
        check("hit_exit30", collision, 0);
        tick(2);
        check("hit_play", collision, 0);

        // No false collision from wrapped differences; finish reached
        obs_en = 4'b0001; set_obs(0, 3, 400);
        BallX = 10'd1020; BallY = 10'd400;
        tick(1);
        check("wrap_cvec", collision_vec, 0);
        check("wrap_fin", finish_line_reached, 1);
        level = 2'd1; BallX = 10'd100; BallY = 10'd100;
        tick(1);
        check("wrap_fin_clr", finish_line_reached, 0);

        // Finish boundary and level release
        obs_en = 4'b0000;
        BallX = 10'd579;
        tick(1);
        check("fin_579", finish_line_reached, 0);
        BallX = 10'd580;
        tick(1);
        check("fin_580", finish_line_reached, 1);
        tick(3);
        check("fin_hold", finish_line_reached, 1);
        level = 2'd0; BallX = 10'd100;
        tick(1);
        check("fin_release", finish_line_reached, 0);

        // Collision beats finish on the same inputs
        obs_en = 4'b0001; set_obs(0, 590, 100);
        BallX = 10'd580; BallY = 10'd100;
        tick(1);
        check("cf_fin0", finish_line_reached, 0);
        check("cf_cvec", collision_vec, 4'b0001);
        tick(1);
        check("cf_coll", collision, 1);
        check("cf_rp", reset_player, 1);
        check("cf_fin1", finish_line_reached, 0);

        // Reset mid-HIT with the pixel pipe full
        BallX = 10'd100;
        DrawX = 10'd100; DrawY = 10'd100; pix_valid = 1'b1;
        tick(3);
        check("pre_rst_valid", rgb_valid, 1);
        Reset_n = 1'b0;
        tick(1);
        check("mid_rst_valid", rgb_valid, 0);
        check("mid_rst_rgb", {Red, Green, Blue}, 0);
        check("mid_rst_cvec", collision_vec, 0);
        check("mid_rst_coll", collision, 0);
        check("mid_rst_rp", reset_player, 0);
        check("mid_rst_fin", finish_line_reached, 0);
        Reset_n = 1'b1; pix_valid = 1'b0;
        tick(2);
        check("post_rst_play", collision, 0);
        BallX = 10'd580;
        tick(2);
        check("fresh_rp", reset_player, 1);
        check("fresh_coll", collision, 1);
        tick(1);
        check("fresh_rp_once", reset_player, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/game_pixel_mapper.md
# game_pixel_mapper

Parametrised successor to the single-obstacle color mapper: it renders the player ball, up to `NUM_OBS` circular obstacles, side borders and a level-shaded background through a registered 3-stage pixel pipeline. It also runs a small play-state FSM that owns collision, player-reset and finish-line signalling. It sits between the VGA/HDMI timing generator (`DrawX`/`DrawY`) and the HDMI encoder, alongside the ball and obstacle motion blocks.

## Interface
- `NUM_OBS`, 4: number of obstacle channels, 1..8.
- `FINISH_X`, 580: ball X at or beyond which the finish line is reached.
- `BORDER_L`, 50: left border; columns with `DrawX <= BORDER_L` are border.
- `BORDER_R`, 590: right border; columns with `DrawX >= BORDER_R` are border.
- `HIT_FRAMES`, 30: number of frames the HIT state lasts.
- `Clk`  in  1  pixel clock.
- `Reset_n`  in  1  reset, synchronous, active-low.
- `frame_start`  in  1  one-cycle pulse at the start of each frame (vsync).
- `pix_valid`  in  1  `DrawX`/`DrawY` lie in the active region.
- `DrawX`, `DrawY`  in  10 each  current pixel coordinates.
- `BallX`, `BallY`, `Ball_size`  in  10 each  ball centre and radius; obstacles use the same radius.
- `ObsX`, `ObsY`  in  10*NUM_OBS each  packed obstacle centres; channel i occupies `[10i+9:10i]`.
- `obs_en`  in  NUM_OBS  per-obstacle enable. A disabled obstacle is neither drawn nor collided.
- `level`  in  2  palette and level select.
- `Red`, `Green`, `Blue`  out  4 each  registered pixel colour.
- `rgb_valid`  out  1  `pix_valid` delayed 3 cycles.
- `collision_vec`  out  NUM_OBS  registered per-obstacle overlap.
- `collision`  out  1  high while the FSM is in HIT.
- `reset_player`  out  1  one-cycle pulse on entry to HIT.
- `finish_line_reached`  out  1  high while the FSM is in FINISH.

## Operation
- **Arithmetic:** all differences are 11-bit signed, sign-extended from 10-bit unsigned inputs. Squares are 21-bit. Sums are 22-bit unsigned. No wrap-around on subtraction.
- **Ball pixel:** `dx² + dy² <= Ball_size²`, where dx and dy are measured from `BallX`/`BallY`.
- **Obstacle pixel i:** same circle test against `ObsX[i]`/`ObsY[i]`, gated by `obs_en[i]`.
- **Pixel priority:** ball, then obstacle (any index), then border, then background.
- **Palette base (R,G,B) by `level`:**
  - 0 → (5,3,3)
  - 1 → (6,4,2)
  - 2 → (F,3,6)
  - 3 → (F,0,0)
- **Colours:**
  - Obstacle colour is the bitwise inverse of the base.
  - Border colour is (0,6,1).
  - Ball colour is (0,F,0) in PLAY and FINISH, and (F,0,0) in HIT.
- **Background shading:** shade = `DrawX[9:7] + DrawY[9:7]` (4-bit). Each channel = base − shade, saturating at 0.
- **Inactive pixels:** when `pix_valid` is low at stage 0, the output colour is (0,0,0).
- **Collision:** `collision_vec[i]` is set when `obs_en[i]` is high and both `|BallX − ObsX[i]| < 2*Ball_size` and `|BallY − ObsY[i]| < 2*Ball_size` hold. These are signed compares, registered every cycle.
- **FSM states:** PLAY, HIT, FINISH. Reset state is PLAY.
- **PLAY:**
  - If any bit of the registered `collision_vec` is set, go to HIT. Pulse `reset_player`, clear the frame counter, and take no other action.
  - Otherwise, if `BallX >= FINISH_X`, go to FINISH and latch `level`.
  - Collision has priority over finish when both occur in the same cycle.
- **HIT:**
  - The frame counter increments on each `frame_start`.
  - When the counter reaches `HIT_FRAMES`, return to PLAY.
  - New collisions are ignored while in HIT.
- **FINISH:** when `level` differs from the latched value, return to PLAY. Collisions are ignored while in FINISH.

## Timing
- **Pixel path latency:** 3 cycles from `DrawX`/`DrawY`/`pix_valid` to `Red`/`Green`/`Blue`/`rgb_valid`.
  - S1 registers the differences.
  - S2 registers the squares and circle compares.
  - S3 registers the priority mux and palette lookup.
  - Ball and obstacle positions and `level` are sampled at S1 alongside the pixel.
- **Collision path:** `collision_vec` is 1 cycle after its inputs. The FSM transition happens the cycle after that. `collision` and `reset_player` are visible 2 cycles after the overlapping inputs.
- **`reset_player`:** exactly one cycle high per HIT entry.
- **`frame_start` on the same cycle as HIT entry:** it does not count toward `HIT_FRAMES`.
- **Reset while `Reset_n` is low at an edge:**
  - All pipeline stages clear, and `rgb_valid` = 0.
  - `Red`/`Green`/`Blue` = 0.
  - `collision_vec` = 0, `collision` = 0, `reset_player` = 0, `finish_line_reached` = 0.
  - FSM goes to PLAY and the frame counter is 0.
  - This applies mid-frame and mid-HIT as well.

## Test plan
- Ball (100,100) radius 8; DrawX=100, DrawY=100, `pix_valid`=1 → after 3 cycles RGB=(0,F,0) and `rgb_valid`=1. Same test with DrawX=130 at level 0 and DrawY=100 → RGB=(5−1−0 saturated) = (4,2,2).
- Obstacle 2 enabled at (200,150); Ball at (190,150) radius 8 → `collision_vec`=4'b0100 after 1 cycle; `reset_player` pulses once and `collision`=1 after 2 cycles; `collision` stays high for exactly 30 `frame_start` pulses, then returns to 0.
- Same geometry with `obs_en[2]`=0 → no collision, and pixel (200,150) shows background or border colour, never (A,C,C) at level 0.
- `BallX`=580 with no overlap → `finish_line_reached`=1 after 1 cycle and holds; change `level` 0→1 → it clears the next cycle. `BallX`=580 with a simultaneous overlap → HIT entered, `finish_line_reached` stays 0.
- Underflow case: Ball at (5,5) radius 8, DrawX=0, DrawY=0 → ball colour shown (signed distance, no wrap). Obstacle at (3,400) while ball at (1000-range wrap values) produces no false collision.
- Assert `Reset_n`=0 for one cycle mid-HIT with `rgb_valid` high → all outputs 0 on the next cycle; the FSM is in PLAY; the next overlap produces a fresh `reset_player` pulse.
